// File: rtl/set_edit_controller_pkg.sv
// Shared state encodings and default timing constants for the set9 edit controller.
// Counters are in ms ticks; CNT_W must be wide enough to hold the timeout.
package set_edit_controller_pkg;

  localparam int LONG_MS_DEF    = 1000;
  localparam int TIMEOUT_MS_DEF = 10000;
  localparam int BLINK_MS_DEF   = 250;
  localparam int CNT_W_DEF      = 14;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HOLD_IN   = 3'd1;
  localparam logic [2:0] ST_EDIT      = 3'd2;
  localparam logic [2:0] ST_HOLD_EDIT = 3'd3;
  localparam logic [2:0] ST_COMMIT    = 3'd4;
  localparam logic [2:0] ST_ABORT     = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    HOLD_IN   = ST_HOLD_IN,
    EDIT      = ST_EDIT,
    HOLD_EDIT = ST_HOLD_EDIT,
    COMMIT    = ST_COMMIT,
    ABORT     = ST_ABORT
  } state_t;

  function automatic logic isEditing(state_t s);
    return (s == EDIT) || (s == HOLD_EDIT);
  endfunction

endpackage

// File: rtl/set_edit_controller_if.sv
// Button/tick inputs and set9 status outputs of the edit controller.
// master drives the buttons and tick; slave is the controller.
interface set_edit_controller_if;
  logic       tick_1ms;
  logic       btnC;
  logic       btnL;
  logic       btnR;
  logic [1:0] set9;
  logic [1:0] pending9;
  logic       edit_mode;
  logic       blink;
  logic       commit_pulse;
  logic       abort_pulse;

  modport master (
    output tick_1ms, btnC, btnL, btnR,
    input  set9, pending9, edit_mode, blink, commit_pulse, abort_pulse
  );

  modport slave (
    input  tick_1ms, btnC, btnL, btnR,
    output set9, pending9, edit_mode, blink, commit_pulse, abort_pulse
  );
endinterface

// File: rtl/set_edit_controller_btn_sync_edge.sv
// Two-flop synchronizer plus edge register for one asynchronous button level.
// An input change is acted on at the 3rd clk edge; no backpressure.
module set_edit_controller_btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btnIn,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta;
  logic synced;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= btnIn;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign level = synced;
  assign rise  = synced & ~prev;
  assign fall  = ~synced & prev;
endmodule

// File: rtl/set_edit_controller.sv
// Abortable edit transaction for the 2-bit set9 register driven by btnC/btnL/btnR.
// set9 changes one clk after COMMIT; pulses are one cycle; inputs are never stalled.
module set_edit_controller
  import set_edit_controller_pkg::*;
#(
  parameter int LONG_MS    = LONG_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int BLINK_MS   = BLINK_MS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  set_edit_controller_if.slave io
);
  localparam logic [CNT_W-1:0] LONG_C     = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);

  logic cLevel, cRise, cFall;
  logic lRise, rRise;
  logic [3:0] unusedLR;

  state_t state, nextState;
  logic [1:0] set9Q, pending9Q, pendNext;
  logic [CNT_W-1:0] holdCnt, idleCnt, blinkCnt;
  logic blinkQ;
  logic longFlag, anyRise;

  set_edit_controller_btn_sync_edge syncC (
    .clk(clk), .reset(reset), .btnIn(io.btnC),
    .level(cLevel), .rise(cRise), .fall(cFall)
  );
  set_edit_controller_btn_sync_edge syncL (
    .clk(clk), .reset(reset), .btnIn(io.btnL),
    .level(unusedLR[0]), .rise(lRise), .fall(unusedLR[1])
  );
  set_edit_controller_btn_sync_edge syncR (
    .clk(clk), .reset(reset), .btnIn(io.btnR),
    .level(unusedLR[2]), .rise(rRise), .fall(unusedLR[3])
  );

  assign longFlag = (holdCnt == LONG_C);
  assign anyRise  = cRise | lRise | rRise;

  // A fresh btnC press restarts the hold measurement; clear wins over a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      holdCnt <= '0;
    end else if (cRise) begin
      holdCnt <= '0;
    end else if (io.tick_1ms && cLevel && (holdCnt != LONG_C)) begin
      holdCnt <= holdCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt <= '0;
    end else if ((state != EDIT) || anyRise) begin
      idleCnt <= '0;
    end else if (io.tick_1ms && (idleCnt != TIMEOUT_C)) begin
      idleCnt <= idleCnt + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    pendNext  = pending9Q;
    unique case (state)
      IDLE: begin
        if (cRise) nextState = HOLD_IN;
      end
      HOLD_IN: begin
        if (longFlag) begin
          nextState = EDIT;
          pendNext  = set9Q;
        end else if (cFall) begin
          nextState = IDLE;
        end
      end
      EDIT: begin
        // btnC wins; an L/R edge in the timeout cycle counts as activity and holds off the abort.
        if (cRise) begin
          nextState = HOLD_EDIT;
        end else if (lRise || rRise) begin
          pendNext = pending9Q ^ {lRise, rRise};
        end else if (idleCnt == TIMEOUT_C) begin
          nextState = ABORT;
        end
      end
      HOLD_EDIT: begin
        if (longFlag) nextState = ABORT;
        else if (cFall) nextState = COMMIT;
      end
      COMMIT: nextState = IDLE;
      ABORT: begin
        nextState = IDLE;
        pendNext  = set9Q;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      set9Q     <= 2'b00;
      pending9Q <= 2'b00;
    end else begin
      state     <= nextState;
      pending9Q <= pendNext;
      if (state == COMMIT) set9Q <= pending9Q;
    end
  end

  // Blink restarts high on edit entry and runs across EDIT/HOLD_EDIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      blinkQ   <= 1'b0;
      blinkCnt <= '0;
    end else if ((state == HOLD_IN) && (nextState == EDIT)) begin
      blinkQ   <= 1'b1;
      blinkCnt <= '0;
    end else if (isEditing(nextState)) begin
      if (io.tick_1ms) begin
        if (blinkCnt == BLINK_LAST) begin
          blinkCnt <= '0;
          blinkQ   <= ~blinkQ;
        end else begin
          blinkCnt <= blinkCnt + 1'b1;
        end
      end
    end else begin
      blinkQ   <= 1'b0;
      blinkCnt <= '0;
    end
  end

  assign io.set9         = set9Q;
  assign io.pending9     = pending9Q;
  assign io.edit_mode    = isEditing(state);
  assign io.blink        = blinkQ;
  assign io.commit_pulse = (state == COMMIT);
  assign io.abort_pulse  = (state == ABORT);
endmodule

// File: tb/tb_set_edit_controller.sv
// Directed plus randomized bench for set_edit_controller against a cycle-level event model.
module tb_set_edit_controller;
  localparam int LONG = 4;
  localparam int TO   = 20;
  localparam int BL   = 2;

  localparam int M_IDLE = 0, M_HOLD_IN = 1, M_EDIT = 2, M_HOLD_EDIT = 3, M_COMMIT = 4, M_ABORT = 5;

  logic clk = 1'b0;
  logic reset;
  set_edit_controller_if io();

  set_edit_controller #(
    .LONG_MS(LONG), .TIMEOUT_MS(TO), .BLINK_MS(BL), .CNT_W(14)
  ) dut (
    .clk(clk), .reset(reset), .io(io)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  bit randTicks = 0;
  int tickPhase = 0;

  // model state: button sample history, event timers, committed/shadow values
  logic [2:0] m1, m2, m3;
  int mode, holdT, idleT, editT;
  logic [1:0] mSet, mPend;

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [2:0] b, lvl, rise, fall;
    bit longNow, timedOut;
    int nMode;
    b = {io.btnC, io.btnL, io.btnR};
    if (reset) begin
      m1 = 0; m2 = 0; m3 = 0;
      mode = M_IDLE; holdT = 0; idleT = 0; editT = 0;
      mSet = 0; mPend = 0;
      return;
    end
    lvl  = m2;
    rise = m2 & ~m3;
    fall = ~m2 & m3;
    m3 = m2; m2 = m1; m1 = b;
    longNow  = (holdT >= LONG);
    timedOut = (idleT >= TO);
    nMode = mode;
    case (mode)
      M_IDLE:    if (rise[2]) nMode = M_HOLD_IN;
      M_HOLD_IN: begin
        if (longNow) begin nMode = M_EDIT; mPend = mSet; end
        else if (fall[2]) nMode = M_IDLE;
      end
      M_EDIT: begin
        if (rise[2]) nMode = M_HOLD_EDIT;
        else if (rise[1] || rise[0]) begin
          if (rise[1]) mPend[1] = ~mPend[1];
          if (rise[0]) mPend[0] = ~mPend[0];
        end else if (timedOut) nMode = M_ABORT;
      end
      M_HOLD_EDIT: begin
        if (longNow) nMode = M_ABORT;
        else if (fall[2]) nMode = M_COMMIT;
      end
      M_COMMIT: begin mSet = mPend; nMode = M_IDLE; end
      default:  begin mPend = mSet; nMode = M_IDLE; end
    endcase
    if (rise[2]) holdT = 0;
    else if (io.tick_1ms && lvl[2]) holdT++;
    if (mode != M_EDIT || rise != 3'b000) idleT = 0;
    else if (io.tick_1ms) idleT++;
    if (mode == M_HOLD_IN && nMode == M_EDIT) editT = 0;
    else if ((nMode == M_EDIT || nMode == M_HOLD_EDIT) && io.tick_1ms) editT++;
    mode = nMode;
  endtask

  function automatic logic [7:0] modelVec();
    bit ed;
    ed = (mode == M_EDIT) || (mode == M_HOLD_EDIT);
    return {mSet, mPend, ed, ed && ((editT / BL) % 2 == 0), mode == M_COMMIT, mode == M_ABORT};
  endfunction

  function automatic logic [7:0] dutVec();
    return {io.set9, io.pending9, io.edit_mode, io.blink, io.commit_pulse, io.abort_pulse};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      #1;
      chk("cycle_outputs", int'(dutVec()), int'(modelVec()));
    end
  end

  initial begin
    io.tick_1ms = 1'b0;
    forever begin
      @(negedge clk);
      if (randTicks) io.tick_1ms = ($urandom_range(0, 3) == 0);
      else io.tick_1ms = (tickPhase == 0);
      tickPhase = (tickPhase + 1) % 4;
    end
  end

  // which: 0 edit_mode, 1 commit_pulse, 2 abort_pulse; counts ticks seen on the way
  task automatic waitFor(input string name, input int which, input int bound, output int ticks);
    bit seen;
    seen = 0;
    ticks = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(posedge clk);
      if (io.tick_1ms) ticks++;
      #1;
      case (which)
        0:       seen = io.edit_mode;
        1:       seen = io.commit_pulse;
        default: seen = io.abort_pulse;
      endcase
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic waitTicks(input int n);
    int got;
    got = 0;
    for (int i = 0; i < n * 8 + 8 && got < n; i++) begin
      @(posedge clk);
      if (io.tick_1ms) got++;
    end
    #1;
  endtask

  task automatic enterEdit(input string name, output int ticks);
    @(negedge clk);
    io.btnC = 1'b1;
    repeat (3) @(posedge clk);
    waitFor(name, 0, 100, ticks);
  endtask

  task automatic releaseAll();
    @(negedge clk);
    io.btnC = 1'b0; io.btnL = 1'b0; io.btnR = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    bit sawEdit;
    reset = 1'b1;
    io.btnC = 1'b0; io.btnL = 1'b0; io.btnR = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(dutVec()), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // long press from reset enters EDIT after exactly LONG ticks
    enterEdit("enter_edit_1", t);
    chk("entry_tick_count", t, 4);
    chk("entry_pending", int'(io.pending9), 0);
    chk("entry_blink", int'(io.blink), 1);
    waitTicks(2);
    chk("blink_after_2_ticks", int'(io.blink), 0);
    waitTicks(2);
    chk("blink_after_4_ticks", int'(io.blink), 1);
    releaseAll();
    chk("edit_after_release", int'(io.edit_mode), 1);

    // btnL toggles bit 1, short btnC commits
    io.btnL = 1'b1;
    repeat (6) @(negedge clk);
    io.btnL = 1'b0;
    repeat (4) @(negedge clk);
    chk("pending_after_L", int'(io.pending9), 2);
    io.btnC = 1'b1;
    repeat (6) @(negedge clk);
    io.btnC = 1'b0;
    waitFor("commit_seen", 1, 20, t);
    chk("set9_during_commit", int'(io.set9), 0);
    chk("edit_in_commit", int'(io.edit_mode), 0);
    @(posedge clk); #1;
    chk("set9_after_commit", int'(io.set9), 2);
    chk("commit_one_cycle", int'(io.commit_pulse), 0);
    releaseAll();

    // btnR edit then long btnC aborts; held button must not re-enter
    enterEdit("enter_edit_2", t);
    chk("entry_pending_loaded", int'(io.pending9), 2);
    releaseAll();
    io.btnR = 1'b1;
    repeat (6) @(negedge clk);
    io.btnR = 1'b0;
    repeat (4) @(negedge clk);
    chk("pending_after_R", int'(io.pending9), 3);
    io.btnC = 1'b1;
    waitFor("abort_long_press", 2, 60, t);
    chk("set9_at_abort", int'(io.set9), 2);
    @(posedge clk); #1;
    chk("pending_restored", int'(io.pending9), 2);
    sawEdit = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      sawEdit |= io.edit_mode;
    end
    chk("no_reentry_while_held", int'(sawEdit), 0);
    releaseAll();

    // simultaneous L+R, then timeout after TO ticks
    enterEdit("enter_edit_3", t);
    releaseAll();
    @(negedge clk);
    io.btnL = 1'b1; io.btnR = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("pending_both_toggled", int'(io.pending9), 1);
    waitFor("timeout_abort", 2, 120, t);
    chk("timeout_tick_count", t, 20);
    chk("set9_after_timeout", int'(io.set9), 2);
    releaseAll();

    // activity at tick 15 restarts the timeout
    enterEdit("enter_edit_4", t);
    releaseAll();
    waitTicks(15);
    @(negedge clk);
    io.btnL = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("pending_after_late_L", int'(io.pending9), 0);
    waitFor("timeout_after_activity", 2, 120, t);
    chk("restarted_tick_count", t, 20);
    releaseAll();

    // reset in the middle of an edit
    enterEdit("enter_edit_5", t);
    releaseAll();
    io.btnL = 1'b1; io.btnR = 1'b1;
    repeat (4) @(negedge clk);
    io.btnL = 1'b0; io.btnR = 1'b0;
    repeat (4) @(negedge clk);
    chk("pending_before_reset", int'(io.pending9), 1);
    chk("set9_before_reset", int'(io.set9), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_edit", int'(dutVec()), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    randTicks = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 23) == 0) io.btnC = ~io.btnC;
      if ($urandom_range(0, 39) == 0) io.btnL = ~io.btnL;
      if ($urandom_range(0, 39) == 0) io.btnR = ~io.btnR;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
